// File: rtl/neurosync_pkg.sv
// Shared definitions for the neurosync game and its automatic player:
// state codes, LED/button width and small one-hot helpers.
package neurosync_pkg;

  localparam int LED_W = 4;

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PARTIDA   = 4'd1,
    ESCUTA    = 4'd2,
    ACESO     = 4'd3,
    PRESSIONA = 4'd4,
    SOLTA     = 4'd5,
    FIM       = 4'd6,
    ERRO      = 4'd7
  } estado_t;

  function automatic logic is_onehot4(input logic [LED_W-1:0] v);
    return ($countones(v) == 1);
  endfunction

  function automatic logic [LED_W-1:0] rotl4(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

endpackage

// File: rtl/memoria_jogadas.sv
// Step memory: one register per captured step, synchronous write and
// asynchronous read so a press can be launched on the same edge it is looked up.
module memoria_jogadas
  import neurosync_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = LED_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] rd_tab [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [W-1:0] entry_reg;

    always_ff @(posedge clock) begin
      if (we && wr_addr == AW'(gi)) begin
        entry_reg <= wr_data;
      end
    end

    assign rd_tab[gi] = entry_reg;
  end

  assign rd_data = rd_tab[rd_addr];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: captures the step sequence shown on leds each round and
// replays it on botoes with fixed press/gap timing; pulses jogar to start a match.
module jogador_automatico
  import neurosync_pkg::*;
#(
  parameter int MAX_JOGADAS  = 16,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             habilita,
  input  logic [LED_W-1:0] leds,
  input  logic             pronto,
  input  logic             timeout,
  input  logic             errar,
  output logic [LED_W-1:0] botoes,
  output logic             jogar,
  output logic             ocupado,
  output logic             erro,
  output logic [3:0]       db_estado,
  output logic [4:0]       db_num_jogadas
);

  localparam int NW    = $clog2(MAX_JOGADAS) + 1;
  localparam int AW    = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
  localparam int CMAX0 = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CMAX  = (CMAX0 > QUIET_CYCLES) ? CMAX0 : QUIET_CYCLES;
  localparam int CW    = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] CNT_SAT = '1;

  estado_t          state_reg;
  logic [NW-1:0]    n_reg;
  logic [NW-1:0]    idx_reg;
  logic [CW-1:0]    quiet_reg;
  logic [CW-1:0]    cnt_reg;
  logic             errar_reg;
  logic [LED_W-1:0] botoes_reg;
  logic             jogar_reg;
  logic             ocupado_reg;
  logic             erro_reg;

  logic             fim_jogo;
  logic             mem_we;
  logic [AW-1:0]    rd_addr;
  logic [LED_W-1:0] mem_rd;

  // Game over preempts everything except the idle/terminal states.
  assign fim_jogo = (pronto || timeout) && !(state_reg inside {INICIAL, FIM, ERRO});

  assign mem_we = !reset && !fim_jogo && (state_reg == ESCUTA) && is_onehot4(leds)
                  && (n_reg != NW'(MAX_JOGADAS));

  // Entering replay reads step 0; leaving a gap reads the following step.
  assign rd_addr = (state_reg == SOLTA) ? AW'(idx_reg + NW'(1)) : '0;

  memoria_jogadas #(
    .DEPTH (MAX_JOGADAS),
    .W     (LED_W),
    .AW    (AW)
  ) u_memoria (
    .clock   (clock),
    .we      (mem_we),
    .wr_addr (n_reg[AW-1:0]),
    .wr_data (leds),
    .rd_addr (rd_addr),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= INICIAL;
      n_reg       <= '0;
      idx_reg     <= '0;
      quiet_reg   <= '0;
      cnt_reg     <= '0;
      errar_reg   <= 1'b0;
      botoes_reg  <= '0;
      jogar_reg   <= 1'b0;
      ocupado_reg <= 1'b0;
      erro_reg    <= 1'b0;
    end else if (fim_jogo) begin
      state_reg   <= FIM;
      botoes_reg  <= '0;
      jogar_reg   <= 1'b0;
      ocupado_reg <= 1'b0;
      erro_reg    <= 1'b0;
    end else begin
      case (state_reg)
        INICIAL: begin
          if (habilita) begin
            state_reg   <= PARTIDA;
            jogar_reg   <= 1'b1;
            ocupado_reg <= 1'b1;
          end
        end
        PARTIDA: begin
          state_reg <= ESCUTA;
          jogar_reg <= 1'b0;
          n_reg     <= '0;
          quiet_reg <= '0;
        end
        ESCUTA: begin
          if (leds != '0) begin
            if (!is_onehot4(leds) || n_reg == NW'(MAX_JOGADAS)) begin
              state_reg <= ERRO;
              erro_reg  <= 1'b1;
            end else begin
              state_reg <= ACESO;
              n_reg     <= n_reg + NW'(1);
            end
          end else begin
            if (quiet_reg != CNT_SAT) begin
              quiet_reg <= quiet_reg + CW'(1);
            end
            if (quiet_reg == CW'(QUIET_CYCLES - 1) && n_reg != '0) begin
              state_reg  <= PRESSIONA;
              idx_reg    <= '0;
              cnt_reg    <= '0;
              errar_reg  <= errar;
              botoes_reg <= (errar && n_reg == NW'(1)) ? rotl4(mem_rd) : mem_rd;
            end
          end
        end
        ACESO: begin
          if (leds == '0) begin
            state_reg <= ESCUTA;
            quiet_reg <= '0;
          end
        end
        PRESSIONA: begin
          if (cnt_reg == CW'(PRESS_CYCLES - 1)) begin
            state_reg  <= SOLTA;
            cnt_reg    <= '0;
            botoes_reg <= '0;
          end else if (cnt_reg != CNT_SAT) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        SOLTA: begin
          if (cnt_reg == CW'(GAP_CYCLES - 1)) begin
            cnt_reg <= '0;
            idx_reg <= idx_reg + NW'(1);
            if (idx_reg + NW'(1) == n_reg) begin
              state_reg <= ESCUTA;
              n_reg     <= '0;
              quiet_reg <= '0;
            end else begin
              state_reg  <= PRESSIONA;
              // Only the final step of the round is corrupted when errar was latched.
              botoes_reg <= (errar_reg && idx_reg + NW'(2) == n_reg) ? rotl4(mem_rd) : mem_rd;
            end
          end else if (cnt_reg != CNT_SAT) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        FIM: begin
          botoes_reg <= '0;
          if (!habilita) begin
            state_reg <= INICIAL;
          end
        end
        ERRO: begin
          botoes_reg <= '0;
          erro_reg   <= 1'b1;
        end
        default: begin
          state_reg   <= INICIAL;
          botoes_reg  <= '0;
          jogar_reg   <= 1'b0;
          ocupado_reg <= 1'b0;
          erro_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign botoes         = botoes_reg;
  assign jogar          = jogar_reg;
  assign ocupado        = ocupado_reg;
  assign erro           = erro_reg;
  assign db_estado      = state_reg;
  assign db_num_jogadas = 5'(n_reg);

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: shows sequences on leds, queues the
// expected replay and compares each press, plus error, game-over and reset cases.
module tb_jogador_automatico;

  localparam int PRESS = 4;
  localparam int GAP   = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] leds;
  logic       pronto;
  logic       timeout;
  logic       errar;
  logic [3:0] botoes;
  logic       jogar;
  logic       ocupado;
  logic       erro;
  logic [3:0] db_estado;
  logic [4:0] db_num_jogadas;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q [$];

  jogador_automatico #(
    .MAX_JOGADAS  (16),
    .PRESS_CYCLES (PRESS),
    .GAP_CYCLES   (GAP),
    .QUIET_CYCLES (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .leds           (leds),
    .pronto         (pronto),
    .timeout        (timeout),
    .errar          (errar),
    .botoes         (botoes),
    .jogar          (jogar),
    .ocupado        (ocupado),
    .erro           (erro),
    .db_estado      (db_estado),
    .db_num_jogadas (db_num_jogadas)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget);
    int w;
    w = 0;
    while (db_estado != code && w < budget) begin
      step();
      w++;
    end
    chk("wait_state", db_estado, code);
  endtask

  // Show one step on leds and queue it as the expected replay value.
  task automatic show(input logic [3:0] v, input int on, input int off);
    leds = v;
    exp_q.push_back(v);
    repeat (on) step();
    leds = 4'b0;
    repeat (off) step();
  endtask

  task automatic replay_check(input int n);
    logic [3:0] e;
    int w;
    int hi;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (botoes == 4'b0 && w < 100) begin
        step();
        w++;
      end
      e = 4'b0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      $display("press %0d: botoes=%b expected=%b", k, botoes, e);
      chk("press_value", botoes, e);
      hi = 0;
      while (botoes == e && e != 4'b0 && hi < 20) begin
        step();
        hi++;
      end
      chk("press_len", hi, PRESS);
      chk("gap_state", db_estado, 4'd5);
      repeat (GAP - 1) step();
      chk("gap_botoes", botoes, 4'b0);
      step();
      chk("after_gap", db_estado, (k == n - 1) ? 4'd2 : 4'd4);
    end
    chk("round_clear", db_num_jogadas, 5'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_botoes"}, botoes, 4'b0);
    chk({tag, "_jogar"}, jogar, 1'b0);
    chk({tag, "_ocupado"}, ocupado, 1'b0);
    chk({tag, "_erro"}, erro, 1'b0);
    chk({tag, "_estado"}, db_estado, 4'd0);
  endtask

  initial begin
    logic [3:0] tmp;
    reset = 1'b1; habilita = 1'b0; leds = 4'b0;
    pronto = 1'b0; timeout = 1'b0; errar = 1'b0;
    repeat (3) step();
    chk_idle("reset");
    chk("reset_num", db_num_jogadas, 5'd0);

    // Start of match: single jogar pulse in PARTIDA.
    reset = 1'b0; habilita = 1'b1;
    step();
    $display("start: estado=%0d jogar=%b", db_estado, jogar);
    chk("partida_estado", db_estado, 4'd1);
    chk("partida_jogar", jogar, 1'b1);
    chk("partida_ocupado", ocupado, 1'b1);
    step();
    chk("escuta_estado", db_estado, 4'd2);
    chk("escuta_jogar", jogar, 1'b0);

    // Basic round with exact quiet-expiry latency.
    show(4'b0001, 5, 0);
    repeat (8) step();
    chk("quiet_botoes", botoes, 4'b0);
    chk("quiet_estado", db_estado, 4'd2);
    chk("quiet_num", db_num_jogadas, 5'd1);
    step();
    chk("rise_estado", db_estado, 4'd4);
    replay_check(1);

    // Three-step round.
    show(4'b0010, 2, 3);
    show(4'b1000, 2, 3);
    show(4'b0100, 2, 0);
    chk("three_num", db_num_jogadas, 5'd3);
    replay_check(3);

    // Corrupted last step.
    errar = 1'b1;
    show(4'b0001, 2, 3);
    show(4'b0010, 2, 0);
    tmp = exp_q[$];
    exp_q[$] = {tmp[2:0], tmp[3]};
    replay_check(2);
    errar = 1'b0;

    // pronto in the middle of a press.
    show(4'b0100, 2, 0);
    wait_state(4'd4, 30);
    step();
    pronto = 1'b1;
    step();
    $display("pronto: estado=%0d botoes=%b", db_estado, botoes);
    chk("pronto_botoes", botoes, 4'b0);
    chk("pronto_estado", db_estado, 4'd6);
    chk("pronto_ocupado", ocupado, 1'b0);
    exp_q.delete();
    pronto = 1'b0; habilita = 1'b0;
    step();
    chk("fim_inicial", db_estado, 4'd0);
    habilita = 1'b1;
    step();
    chk("restart_jogar", jogar, 1'b1);
    step();
    chk("restart_escuta", db_estado, 4'd2);
    timeout = 1'b1;
    step();
    chk("timeout_fim", db_estado, 4'd6);
    timeout = 1'b0; habilita = 1'b0;
    step();

    // Non-one-hot leds go to ERRO.
    habilita = 1'b1;
    wait_state(4'd2, 10);
    leds = 4'b0011;
    step();
    $display("bad leds: estado=%0d erro=%b", db_estado, erro);
    chk("bad_estado", db_estado, 4'd7);
    chk("bad_erro", erro, 1'b1);
    chk("bad_botoes", botoes, 4'b0);
    leds = 4'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Seventeenth capture overflows the step memory.
    wait_state(4'd2, 10);
    for (int i = 0; i < 16; i++) begin
      show(4'b0001 << (i % 4), 1, 1);
    end
    chk("full_num", db_num_jogadas, 5'd16);
    leds = 4'b1000;
    step();
    $display("overflow: estado=%0d erro=%b", db_estado, erro);
    chk("overflow_estado", db_estado, 4'd7);
    chk("overflow_erro", erro, 1'b1);
    exp_q.delete();
    leds = 4'b0;

    // Reset in ACESO.
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_state(4'd2, 10);
    leds = 4'b1000;
    step();
    chk("aceso_estado", db_estado, 4'd3);
    reset = 1'b1;
    step();
    chk_idle("rst_aceso");
    reset = 1'b0; leds = 4'b0;

    // Reset in PRESSIONA.
    wait_state(4'd2, 10);
    show(4'b0010, 1, 0);
    wait_state(4'd4, 30);
    chk("press_botoes", botoes, 4'b0010);
    reset = 1'b1;
    step();
    chk_idle("rst_press");
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
